// File: rtl/dsp_wb_regfile_if.sv
// Wishbone B4 classic bus bundle for the DSP register file.
//   master modport: drives address/data/select/we/cyc/stb/cti/bte, receives
//                   read data and the ack/err/rty terminations.
//   slave modport : the mirror image, used by dsp_wb_regfile.
interface dsp_wb_regfile_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic [aw-1:0] wb_adr_i;
  logic [dw-1:0] wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [dw-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
           wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/dsp_wb_regfile.sv
// DSP block register file: Wishbone B4 classic slave with CTRL, STATUS,
// a sample FIFO drained by the bus, THRESH and CHANNELS coefficient registers.
// Ports:
//   wb_clk, wb_rst  clock, asynchronous active-high reset
//   wb              Wishbone slave (dsp_wb_regfile_if.slave)
//   smp_valid_i/smp_data_i  sample push from the DSP datapath
//   dsp_en_o        CTRL.enable
//   coef_o          coefficient n at bits [n*dw +: dw]
//   irq_o           registered level interrupt
// Map (byte offsets): 0x00 CTRL, 0x04 STATUS, 0x08 FIFO, 0x0C THRESH,
// 0x10+4n COEF[n]. Every access terminates one cycle after it is accepted.

// One coefficient register with per-byte write enables.
module dsp_wb_regfile_coef #(
  parameter int dw = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [dw-1:0] d,
  output logic [dw-1:0] q
);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                q[b*8 +: 8] <= '0;
      else if (we && sel[b])  q[b*8 +: 8] <= d[b*8 +: 8];
    end
  end
endmodule

module dsp_wb_regfile #(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DEBUG      = 0
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  dsp_wb_regfile_if.slave          wb,
  input  logic                     smp_valid_i,
  input  logic [dw-1:0]            smp_data_i,
  output logic                     dsp_en_o,
  output logic [CHANNELS*dw-1:0]   coef_o,
  output logic                     irq_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // Elaboration-time parameter sanity. DEBUG only selects simulation-side
  // tracing, which lives outside this synthesizable file.
  if (dw != 32) begin : g_bad_dw
    $error("dsp_wb_regfile: dw must be 32");
  end
  if (aw < 8) begin : g_bad_aw
    $error("dsp_wb_regfile: aw must be at least 8");
  end
  if (CHANNELS < 1 || CHANNELS > 44) begin : g_bad_ch
    $error("dsp_wb_regfile: CHANNELS must be 1..44");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (1 << PW) != FIFO_DEPTH) begin : g_bad_depth
    $error("dsp_wb_regfile: FIFO_DEPTH must be a power of two in 2..256");
  end
  if (DEBUG != 0 && DEBUG != 1) begin : g_bad_dbg
    $error("dsp_wb_regfile: DEBUG must be 0 or 1");
  end

  // Register state
  logic                         ctrl_en, irq_en, ovf;
  logic [7:0]                   thresh;
  logic [PW-1:0]                wp, rp;
  logic [LW-1:0]                level;
  logic [dw-1:0]                mem [FIFO_DEPTH];
  logic [CHANNELS-1:0][dw-1:0]  coef_q;

  // Decode
  logic [5:0]  off;
  logic        req, is_ctrl, is_stat, is_fifo, is_thr, is_coef, mapped;
  logic        empty, full;
  logic        t_ack, t_err, t_rty;
  logic        wr, rd, pop, clr, push, push_ok;
  logic [7:0]  lvl8;
  logic [dw-1:0] rdata;

  assign off     = wb.wb_adr_i[7:2];
  // A new request is only seen once the previous termination has dropped.
  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~(wb.wb_ack_o | wb.wb_err_o | wb.wb_rty_o);
  assign is_ctrl = (off == 6'd0);
  assign is_stat = (off == 6'd1);
  assign is_fifo = (off == 6'd2);
  assign is_thr  = (off == 6'd3);
  assign is_coef = (off >= 6'd4) && (off < 6'(4 + CHANNELS));
  assign mapped  = is_ctrl | is_stat | is_fifo | is_thr | is_coef;
  assign empty   = (level == '0);
  assign full    = (level == LW'(FIFO_DEPTH));
  // With FIFO_DEPTH=256 the 9-bit level does not fit the 8-bit field; full flags that case.
  assign lvl8    = 8'(level);

  always_comb begin
    t_ack = 1'b0;
    t_err = 1'b0;
    t_rty = 1'b0;
    if (!mapped || wb.wb_sel_i == 4'b0 || (wb.wb_we_i && is_fifo)) t_err = 1'b1;
    else if (!wb.wb_we_i && is_fifo && empty)                       t_rty = 1'b1;
    else                                                            t_ack = 1'b1;
  end

  // All side effects happen on the edge that accepts the request.
  assign wr      = req & t_ack & wb.wb_we_i;
  assign rd      = req & t_ack & ~wb.wb_we_i;
  assign pop     = rd & is_fifo;
  assign clr     = wr & is_ctrl & wb.wb_sel_i[0] & wb.wb_dat_i[1];
  assign push    = smp_valid_i & ctrl_en;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push_ok = push & ~clr & (~full | pop);

  always_comb begin
    rdata = '0;
    if (is_ctrl)      rdata = {29'b0, irq_en, 1'b0, ctrl_en};
    else if (is_stat) rdata = {16'b0, lvl8, 5'b0, ovf, full, empty};
    else if (is_fifo) rdata = mem[rp];
    else if (is_thr)  rdata = {24'b0, thresh};
    else begin
      for (int n = 0; n < CHANNELS; n++)
        if (off == 6'(4 + n)) rdata = coef_q[n];
    end
  end

  // Bus terminations and registered read data
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      wb.wb_rty_o <= 1'b0;
      wb.wb_dat_o <= '0;
    end else begin
      wb.wb_ack_o <= req & t_ack;
      wb.wb_err_o <= req & t_err;
      wb.wb_rty_o <= req & t_rty;
      wb.wb_dat_o <= rd ? rdata : '0;
    end
  end

  // CTRL / THRESH (only byte 0 carries bits)
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ctrl_en <= 1'b0;
      irq_en  <= 1'b0;
      thresh  <= '0;
    end else if (wr && wb.wb_sel_i[0]) begin
      if (is_ctrl) begin
        ctrl_en <= wb.wb_dat_i[0];
        irq_en  <= wb.wb_dat_i[2];
      end
      if (is_thr) thresh <= wb.wb_dat_i[7:0];
    end
  end

  // FIFO pointers, level and sticky overflow
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (clr) begin
        wp    <= '0;
        rp    <= '0;
        level <= '0;
      end else begin
        if (push_ok) wp <= wp + PW'(1);
        if (pop)     rp <= rp + PW'(1);
        case ({push_ok, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: ;
        endcase
      end
      // A fresh overflow wins over a simultaneous W1C.
      if (push && !clr && full && !pop)                         ovf <= 1'b1;
      else if (wr && is_stat && wb.wb_sel_i[0] && wb.wb_dat_i[2]) ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push_ok) mem[wp] <= smp_data_i;
  end

  // Coefficient bank
  for (genvar n = 0; n < CHANNELS; n++) begin : g_coef
    dsp_wb_regfile_coef #(.dw(dw)) u_coef (
      .clk (wb_clk),
      .rst (wb_rst),
      .we  (wr && off == 6'(4 + n)),
      .sel (wb.wb_sel_i),
      .d   (wb.wb_dat_i),
      .q   (coef_q[n])
    );
  end
  assign coef_o   = coef_q;
  assign dsp_en_o = ctrl_en;

  // Interrupt
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) irq_o <= 1'b0;
    else        irq_o <= irq_en & (((thresh != 8'd0) && (9'(level) >= {1'b0, thresh})) | ovf);
  end
endmodule
